fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, queue entry layout and fetch FSM encoding for the fetch queue.
package fetch_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  // One queued instruction: the address after it plus the instruction word.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  // FETCH: responses are kept. DRAIN: responses from before a redirect are dropped.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular entry store for the fetch queue: storage, read/write pointers,
// occupancy count and a single-cycle flush. Push and pop in the same cycle
// are allowed at any occupancy, including full.
module fetch_queue_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [ENTRY_W-1:0]   push_data,
  input  logic                 pop,
  output logic [ENTRY_W-1:0]   head,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Entry storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under a credit rule
// (queued + inflight < DEPTH), buffers in-order responses with their pc+4,
// and on redirect flushes and drops responses still owed by the memory.
// Optional build macro FETCH_QUEUE_BYPASS_EN: a response arriving while the
// queue is empty, not draining and the consumer is ready is presented on the
// outputs in the same cycle instead of being written.
//
// Handshakes: mem request is taken on the edge where mem_req_o && mem_gnt_i;
// mem_rvalid_i is a one-cycle, in-order response with no backpressure;
// an entry is consumed on the edge where out_valid_o && out_ready_i, and a
// stalled entry stays stable until consumed or redirected.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_plus4_o,
  input  logic               out_ready_i,
  output logic               dbg_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

  fetch_state_t        state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   resp_pc;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       inflight_rem;
  logic [CW-1:0]       drop_cnt;
  logic [CW-1:0]       count;
  logic                empty;
  logic [ENTRY_W-1:0]  head_raw;
  entry_t              head;
  entry_t              push_entry;
  logic                grant;
  logic                keep_resp;
  logic                bypass;
  logic                push;
  logic                pop;

  // Request credit, response routing and consumer handshake decode.
  always_comb begin
    mem_req_o    = !redirect_i && (({1'b0, count} + {1'b0, inflight}) < DEPTH_W);
    mem_addr_o   = fetch_pc;
    grant        = mem_req_o && mem_gnt_i;
    inflight_rem = inflight - {{(CW-1){1'b0}}, mem_rvalid_i};
    keep_resp    = mem_rvalid_i && !redirect_i && (state == ST_FETCH);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass       = keep_resp && empty && out_ready_i;
`else
    bypass       = 1'b0;
`endif
    push         = keep_resp && !bypass;
    pop          = !empty && !redirect_i && out_ready_i;
    push_entry.pc_plus4 = resp_pc + 32'd4;
    push_entry.instr    = mem_rdata_i;
    head         = head_raw;
  end

  // Offered entry: queue head, else the bypassed response, else all zero.
  always_comb begin
    out_valid_o    = 1'b0;
    out_instr_o    = '0;
    out_pc_plus4_o = '0;
    if (!empty && !redirect_i) begin
      out_valid_o    = 1'b1;
      out_instr_o    = head.instr;
      out_pc_plus4_o = head.pc_plus4;
    end else if (bypass) begin
      out_valid_o    = 1'b1;
      out_instr_o    = mem_rdata_i;
      out_pc_plus4_o = resp_pc + 32'd4;
    end
  end

  // Fetch/response address tracking, inflight accounting and FETCH/DRAIN FSM.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_rem + {{(CW-1){1'b0}}, grant};
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        drop_cnt <= inflight_rem;
        state    <= (inflight_rem != '0) ? ST_DRAIN : ST_FETCH;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (mem_rvalid_i) begin
          if (state == ST_DRAIN) begin
            drop_cnt <= drop_cnt - ONE;
            if (drop_cnt == ONE) state <= ST_FETCH;
          end else begin
            resp_pc <= resp_pc + 32'd4;
          end
        end
      end
    end
  end

  assign dbg_state = (state == ST_DRAIN);

  fetch_queue_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_raw),
    .empty     (empty),
    .count     (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a cycle-stepped memory model plus a scoreboard of
// the instruction stream the consumer must see, and a direct check of the
// queue store under simultaneous push/pop at full occupancy.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP_SAME = 1'b1;
`else
  localparam bit BYP_SAME = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_plus4_o;
  logic        out_ready_i = 1'b0;
  logic        dbg_state;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o),
    .out_instr_o(out_instr_o), .out_pc_plus4_o(out_pc_plus4_o), .out_ready_i(out_ready_i),
    .dbg_state(dbg_state)
  );

  // Standalone queue store for the full-occupancy push/pop scenario
  logic        f_flush = 1'b0;
  logic        f_push = 1'b0;
  logic        f_pop = 1'b0;
  logic [63:0] f_din = '0;
  logic [63:0] f_head;
  logic        f_empty;
  logic [2:0]  f_count;

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .push(f_push), .push_data(f_din),
    .pop(f_pop), .head(f_head), .empty(f_empty), .count(f_count)
  );

  // Reference model: memory owes responses in grant order; the consumer must
  // see every granted, non-flushed address in order as {addr+4, mem[addr]}.
  typedef struct { logic [31:0] addr; bit drop; } pend_t;
  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] model_pc = RESET_PC;
  int          occ = 0;
  int          n_grants = 0;
  int          gnt_pct = 100, rsp_pct = 100, rdy_pct = 100;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Driver: one clock cycle of stimulus, sampling and scoreboard update
  task automatic step(input bit do_redir, input logic [31:0] rpc);
    bit draining, kept, exp_req, exp_valid, bypass_ok, consume, grant;
    @(negedge clk);
    redirect_i    = do_redir;
    redirect_pc_i = rpc;
    mem_gnt_i     = ($urandom_range(0, 99) < gnt_pct);
    mem_rvalid_i  = (pend_q.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
    if (mem_rvalid_i) mem_rdata_i = mem_data(pend_q[0].addr);
    else mem_rdata_i = $urandom;
    out_ready_i   = ($urandom_range(0, 99) < rdy_pct);
    #1;
    draining = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].drop) draining = 1'b1;
    kept = 1'b0;
    if (mem_rvalid_i && !do_redir && !pend_q[0].drop) kept = 1'b1;
    exp_req   = !do_redir && ((occ + pend_q.size()) < DEPTH);
    bypass_ok = BYP_SAME && (occ == 0) && kept && out_ready_i;
    exp_valid = ((occ > 0) && !do_redir) || bypass_ok;

    checks++;
    if (dbg_state !== draining) begin
      errors++; $display("FAIL drain_state act=%b exp=%b t=%0t", dbg_state, draining, $time);
    end
    checks++;
    if (mem_req_o !== exp_req) begin
      errors++; $display("FAIL mem_req act=%b exp=%b t=%0t", mem_req_o, exp_req, $time);
    end
    if (exp_req) begin
      checks++;
      if (mem_addr_o !== model_pc) begin
        errors++; $display("FAIL mem_addr act=%h exp=%h t=%0t", mem_addr_o, model_pc, $time);
      end
    end
    checks++;
    if (out_valid_o !== exp_valid) begin
      errors++; $display("FAIL out_valid act=%b exp=%b t=%0t", out_valid_o, exp_valid, $time);
    end
    if (exp_valid && exp_q.size() > 0) begin
      checks++;
      if ({out_pc_plus4_o, out_instr_o} !== exp_q[0]) begin
        errors++; $display("FAIL out_entry act=%h exp=%h t=%0t", {out_pc_plus4_o, out_instr_o}, exp_q[0], $time);
      end
    end else if (!exp_valid) begin
      checks++;
      if ({out_pc_plus4_o, out_instr_o} !== 64'd0) begin
        errors++; $display("FAIL out_idle_zero act=%h exp=0 t=%0t", {out_pc_plus4_o, out_instr_o}, $time);
      end
    end

    consume = exp_valid && out_ready_i;
    if (consume) begin
      got_pc.push_back(out_pc_plus4_o);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    grant = exp_req && mem_gnt_i;
    if (grant) begin
      n_grants++;
      pend_q.push_back('{addr: model_pc, drop: 1'b0});
      exp_q.push_back({model_pc + 32'd4, mem_data(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (mem_rvalid_i) void'(pend_q.pop_front());
    occ = occ + int'(kept) - int'(consume);
    if (do_redir) begin
      foreach (pend_q[i]) pend_q[i].drop = 1'b1;
      exp_q.delete();
      occ = 0;
      model_pc = rpc;
    end
  endtask

  task automatic clear_model();
    pend_q.delete(); exp_q.delete(); got_pc.delete();
    occ = 0; n_grants = 0; model_pc = RESET_PC;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; out_ready_i = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", out_valid_o); end
    checks++;
    if (out_instr_o !== 32'd0) begin errors++; $display("FAIL reset_instr act=%h exp=0", out_instr_o); end
    checks++;
    if (out_pc_plus4_o !== 32'd0) begin errors++; $display("FAIL reset_pc4 act=%h exp=0", out_pc_plus4_o); end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin errors++; $display("FAIL first_req act=%b exp=1", mem_req_o); end
    checks++;
    if (mem_addr_o !== RESET_PC) begin errors++; $display("FAIL first_addr act=%h exp=%h", mem_addr_o, RESET_PC); end
  endtask

  task automatic test_stream();
    apply_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 30; i++) step(1'b0, 32'd0);
    checks++;
    if (got_pc.size() < 3) begin
      errors++; $display("FAIL stream_count act=%0d exp>=3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_pc[i] !== 32'(4 * (i + 1))) begin
          errors++; $display("FAIL stream_order idx=%0d act=%h exp=%h", i, got_pc[i], 32'(4 * (i + 1)));
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0);
    checks++;
    if (n_grants !== 4) begin errors++; $display("FAIL stall_grants act=%0d exp=4", n_grants); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'd0);
      checks++;
      if (!(out_valid_o === 1'b1 && out_pc_plus4_o === 32'd4 && mem_req_o === 1'b0)) begin
        errors++; $display("FAIL stall_hold act=v%b pc4=%h req=%b exp=v1 pc4=4 req=0", out_valid_o, out_pc_plus4_o, mem_req_o);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 100;
    step(1'b0, 32'd0);
    step(1'b0, 32'd0);
    gnt_pct = 0;
    step(1'b1, 32'h0000_0100);
    got_pc.delete();
    gnt_pct = 100; rsp_pct = 100;
    step(1'b0, 32'd0);
    checks++;
    if (dbg_state !== 1'b1) begin errors++; $display("FAIL redirect_drain act=%b exp=1", dbg_state); end
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0);
    checks++;
    if (got_pc.size() == 0) begin
      errors++; $display("FAIL redirect_none act=0 exp>0");
    end else if (got_pc[0] !== 32'h0000_0104) begin
      errors++; $display("FAIL redirect_first act=%h exp=00000104", got_pc[0]);
    end
  endtask

  task automatic test_full_stream();
    apply_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0);
    rdy_pct = 100;
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0);
    checks++;
    if (got_pc.size() < 10) begin errors++; $display("FAIL full_stream_count act=%0d exp>=10", got_pc.size()); end
    foreach (got_pc[i]) begin
      checks++;
      if (got_pc[i] !== 32'(4 * (i + 1))) begin
        errors++; $display("FAIL full_stream_order idx=%0d act=%h exp=%h", i, got_pc[i], 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_fifo_push_pop_full();
    logic [63:0] vals [5];
    apply_reset();
    foreach (vals[i]) vals[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); f_push = 1'b1; f_din = vals[i];
    end
    @(negedge clk); f_push = 1'b0;
    #1;
    checks++;
    if (f_count !== 3'd4) begin errors++; $display("FAIL fifo_fill act=%0d exp=4", f_count); end
    @(negedge clk); f_push = 1'b1; f_pop = 1'b1; f_din = vals[4];
    #1;
    checks++;
    if (f_head !== vals[0]) begin errors++; $display("FAIL fifo_head0 act=%h exp=%h", f_head, vals[0]); end
    @(negedge clk); f_push = 1'b0; f_pop = 1'b0;
    #1;
    checks++;
    if (f_count !== 3'd4) begin errors++; $display("FAIL fifo_pushpop_full act=%0d exp=4", f_count); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); f_pop = 1'b1;
      #1;
      checks++;
      if (f_head !== vals[i]) begin errors++; $display("FAIL fifo_order idx=%0d act=%h exp=%h", i, f_head, vals[i]); end
    end
    @(negedge clk); f_pop = 1'b0;
    #1;
    checks++;
    if (f_empty !== 1'b1) begin errors++; $display("FAIL fifo_drain act=%b exp=1", f_empty); end
    @(negedge clk); f_push = 1'b1; f_din = vals[0];
    @(negedge clk); f_push = 1'b0; f_flush = 1'b1;
    @(negedge clk); f_flush = 1'b0;
    #1;
    checks++;
    if (f_count !== 3'd0) begin errors++; $display("FAIL fifo_flush act=%0d exp=0", f_count); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    apply_reset();
    gnt_pct = 60; rsp_pct = 60; rdy_pct = 60;
    for (int i = 0; i < 500; i++) begin
      if (i == 100) step(1'b1, 32'hFFFF_FFF8);
      else if ($urandom_range(0, 39) == 0) begin
        rpc = $urandom & 32'hFFFF_FFFC;
        step(1'b1, rpc);
      end else step(1'b0, 32'd0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0);
    checks++;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid act=%b exp=1", out_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_instr_o, out_pc_plus4_o} !== 65'd0) begin
      errors++; $display("FAIL async_reset_out act=%b/%h/%h exp=0", out_valid_o, out_instr_o, out_pc_plus4_o);
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; out_ready_i = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (!(mem_req_o === 1'b1 && mem_addr_o === RESET_PC)) begin
      errors++; $display("FAIL refetch act=req%b addr=%h exp=req1 addr=%h", mem_req_o, mem_addr_o, RESET_PC);
    end
    rdy_pct = 100;
    for (int i = 0; i < 10; i++) step(1'b0, 32'd0);
    checks++;
    if (got_pc.size() == 0 || got_pc[0] !== RESET_PC + 32'd4) begin
      errors++; $display("FAIL refetch_first act_n=%0d exp=%h", got_pc.size(), RESET_PC + 32'd4);
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 100;
    step(1'b0, 32'd0);
    gnt_pct = 0; rsp_pct = 100;
    step(1'b0, 32'd0);
    checks++;
    if (out_valid_o !== BYP_SAME) begin errors++; $display("FAIL bypass_same act=%b exp=%b", out_valid_o, BYP_SAME); end
    step(1'b0, 32'd0);
    checks++;
    if (out_valid_o !== !BYP_SAME) begin errors++; $display("FAIL bypass_next act=%b exp=%b", out_valid_o, !BYP_SAME); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_full_stream();
    test_fifo_push_pop_full();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
